// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the default operand width.
package alu_pkg;

   localparam int ALU_WIDTH = 3;

   // Only the multiply opcode is consumed here; 00/01/10 belong to sibling units.
   localparam logic [1:0] OP_MUL = 2'b11;

endpackage : alu_pkg

// File: rtl/array_mult.sv
// Combinational unsigned WIDTH x WIDTH array multiplier.
// AND-gate partial products summed through ripple-carry adder rows.
module array_mult #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] prod_o
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0] acc   [0:WIDTH];
   logic [PW-1:0] pp_row;
   logic          carry;

   // Row i adds (a & b[i]) << i into the running sum; each row is a bit-serial ripple chain.
   always_comb begin
      for (int r = 0; r <= WIDTH; r++) begin
         acc[r] = '0;
      end
      pp_row = '0;
      carry  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         pp_row = {{WIDTH{1'b0}}, (a_i & {WIDTH{b_i[i]}})} << i;
         carry  = 1'b0;
         for (int k = 0; k < PW; k++) begin
            acc[i+1][k] = acc[i][k] ^ pp_row[k] ^ carry;
            carry       = (acc[i][k] & pp_row[k]) | (carry & (acc[i][k] ^ pp_row[k]));
         end
      end
   end

   // The full-precision product never overflows 2*WIDTH bits, so the final carry is always 0.
   assign prod_o = acc[WIDTH];

endmodule : array_mult

// File: rtl/multiplier_alu.sv
// Registered unsigned multiplier slice of the ALU. Loads A*B when enabled
// with the multiply opcode; otherwise holds the last product.
module multiplier_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] Doutmult
);

   logic                 load;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   dout_d;
   logic [2*WIDTH-1:0]   dout_q;

   array_mult #(
      .WIDTH (WIDTH)
   ) u_array_mult (
      .a_i    (A),
      .b_i    (B),
      .prod_o (prod)
   );

   assign load = en && (op == OP_MUL);

   // Next product: new value on a qualifying edge, otherwise hold (no clearing on other opcodes).
   always_comb begin
      dout_d = dout_q;
      if (load) begin
         dout_d = prod;
      end
   end

   // Output register; reset clears it immediately and dominates any load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign Doutmult = dout_q;

endmodule : multiplier_alu

// File: tb/tb_multiplier_alu.sv
// Self-checking bench for multiplier_alu: directed table, reset corners,
// exhaustive operand sweep and randomized traffic against a product model.
module tb_multiplier_alu;

   localparam int W = 3;

   logic           clk;
   logic           rst_n;
   logic           en;
   logic [1:0]     op;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-1:0] Doutmult;

   int checks = 0;
   int errors = 0;
   int model  = 0;   // last product the unit should be holding

   typedef struct {
      logic       en;
      logic [1:0] op;
      int         a;
      int         b;
      int         exp;
   } vec_t;

   vec_t vecs [$];

   multiplier_alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .op       (op),
      .A        (A),
      .B        (B),
      .Doutmult (Doutmult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2*W-1:0] act, input int exp);
      checks++;
      if (act !== exp[2*W-1:0]) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
   task automatic step(input logic e, input logic [1:0] o, input int a, input int b);
      @(negedge clk);
      en = e; op = o; A = a[W-1:0]; B = b[W-1:0];
      @(posedge clk);
      #1;
      if (e && o == 2'b11) model = a * b;
   endtask

   function automatic vec_t mk(input logic e, input logic [1:0] o, input int a, input int b, input int x);
      vec_t v;
      v.en = e; v.op = o; v.a = a; v.b = b; v.exp = x;
      return v;
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b0; op = 2'b00; A = '0; B = '0;

      vecs.push_back(mk(1, 2'b11, 1, 0, 0));
      vecs.push_back(mk(1, 2'b11, 1, 1, 1));
      vecs.push_back(mk(1, 2'b11, 3, 1, 3));
      vecs.push_back(mk(1, 2'b11, 3, 3, 9));
      vecs.push_back(mk(1, 2'b11, 6, 3, 18));
      vecs.push_back(mk(1, 2'b11, 6, 6, 36));
      vecs.push_back(mk(1, 2'b11, 7, 6, 42));
      vecs.push_back(mk(1, 2'b11, 7, 7, 49));
      vecs.push_back(mk(1, 2'b01, 2, 2, 49));   // other opcode holds
      vecs.push_back(mk(1, 2'b00, 3, 3, 49));
      vecs.push_back(mk(1, 2'b10, 4, 4, 49));
      vecs.push_back(mk(0, 2'b11, 5, 5, 49));   // enable low holds
      vecs.push_back(mk(1, 2'b11, 5, 5, 25));
      vecs.push_back(mk(1, 2'b11, 7, 7, 49));   // back-to-back alternation
      vecs.push_back(mk(1, 2'b11, 0, 5, 0));
      vecs.push_back(mk(1, 2'b11, 7, 7, 49));
      vecs.push_back(mk(1, 2'b11, 0, 5, 0));

      #2;
      check("reset_initial", Doutmult, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("table[%0d]", i), Doutmult, vecs[i].exp);
      end

      // Asynchronous reset mid-cycle from a nonzero value.
      step(1, 2'b11, 7, 7);
      check("pre_reset", Doutmult, 49);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", Doutmult, 0);

      // Qualifying edge while reset is held: reset wins.
      @(negedge clk);
      en = 1'b1; op = 2'b11; A = 3'd7; B = 3'd7;
      @(posedge clk);
      #1;
      check("reset_beats_load", Doutmult, 0);

      // First edge after release loads.
      @(negedge clk);
      rst_n = 1'b1;
      model = 0;
      @(posedge clk);
      #1;
      model = 49;
      check("first_load_after_reset", Doutmult, 49);

      // Exhaustive operand sweep.
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            step(1, 2'b11, a, b);
            check($sformatf("exh_%0dx%0d", a, b), Doutmult, a * b);
         end
      end

      // Random traffic: enable and opcode vary, model keeps the last loaded product.
      for (int n = 0; n < 300; n++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         check($sformatf("rand[%0d]", n), Doutmult, model);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multiplier_alu
